// File: rtl/shader_pkg.sv
// Shared types and width helpers for the shader-path intensity stages.
package shader_pkg;

  localparam int NORM_WIDTH_DEF = 16;
  localparam int NORM_FRAC_DEF  = 14;
  localparam int ONE            = 1 << NORM_FRAC_DEF;

  // Packed as {x, y, z}, each NORM_WIDTH_DEF bits, signed Q(NORM_FRAC_DEF).
  typedef logic signed [3*NORM_WIDTH_DEF-1:0] vec3_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  function automatic int full_w(int nw, int nf);
    return 2 + 2 * nw - nf;
  endfunction

  function automatic int acc_w(int nw, int nf, int nl);
    return full_w(nw, nf) + $clog2(nl + 1) + 1;
  endfunction

  function automatic int idx_w(int nl);
    return (nl > 1) ? $clog2(nl) : 1;
  endfunction

  function automatic int one_q(int nf);
    return 1 << nf;
  endfunction

endpackage

// File: rtl/fixed_point_fast_dot.sv
// Pipelined signed 3-component dot product, result in Q(NORM_FRAC) at full width.
// One product stage, one sum/shift stage, then LATENCY-2 delay stages.
module fixed_point_fast_dot
  import shader_pkg::*;
#(
  parameter int NORM_WIDTH = 16,
  parameter int NORM_FRAC  = 14,
  parameter int LATENCY    = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [3*NORM_WIDTH-1:0]                               a,
  input  logic [3*NORM_WIDTH-1:0]                               b,
  output logic signed [full_w(NORM_WIDTH, NORM_FRAC)-1:0]       y
);

  localparam int FULL_W = full_w(NORM_WIDTH, NORM_FRAC);
  localparam int PROD_W = 2 * NORM_WIDTH;
  localparam int SUM_W  = 2 * NORM_WIDTH + 2;

  logic signed [NORM_WIDTH-1:0] ax, ay, az, bx, by, bz;
  logic signed [PROD_W-1:0]     p_q [3];
  logic signed [SUM_W-1:0]      sum;
  logic signed [FULL_W-1:0]     sum_sh;
  logic signed [FULL_W-1:0]     pipe_q [LATENCY-1];

  assign ax = a[3*NORM_WIDTH-1:2*NORM_WIDTH];
  assign ay = a[2*NORM_WIDTH-1:NORM_WIDTH];
  assign az = a[NORM_WIDTH-1:0];
  assign bx = b[3*NORM_WIDTH-1:2*NORM_WIDTH];
  assign by = b[2*NORM_WIDTH-1:NORM_WIDTH];
  assign bz = b[NORM_WIDTH-1:0];

  // Arithmetic shift drops only fraction bits; the truncation removes redundant sign bits.
  assign sum    = SUM_W'(p_q[0]) + SUM_W'(p_q[1]) + SUM_W'(p_q[2]);
  assign sum_sh = FULL_W'(sum >>> NORM_FRAC);
  assign y      = pipe_q[LATENCY-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) p_q[i] <= '0;
      for (int k = 0; k < LATENCY - 1; k++) pipe_q[k] <= '0;
    end else begin
      p_q[0]    <= PROD_W'(ax) * PROD_W'(bx);
      p_q[1]    <= PROD_W'(ay) * PROD_W'(by);
      p_q[2]    <= PROD_W'(az) * PROD_W'(bz);
      pipe_q[0] <= sum_sh;
      for (int k = 1; k < LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

endmodule

// File: rtl/light_dir_regfile.sv
// Directional light store: one write port (only while the stage is idle) and one
// combinational read port indexed by slot number (slot 0 has no light and reads zero).
module light_dir_regfile
  import shader_pkg::*;
#(
  parameter int NORM_WIDTH = 16,
  parameter int NUM_LIGHTS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_allow,
  input  logic                              wr_en,
  input  logic [idx_w(NUM_LIGHTS)-1:0]      wr_idx,
  input  logic [3*NORM_WIDTH-1:0]           wr_dir,
  input  logic [$clog2(NUM_LIGHTS+1)-1:0]   rd_slot,
  output logic [3*NORM_WIDTH-1:0]           rd_dir
);

  localparam int IDX_W = idx_w(NUM_LIGHTS);
  localparam int DEPTH = 1 << IDX_W;

  logic [3*NORM_WIDTH-1:0] regs_q [DEPTH];
  logic [IDX_W-1:0]        rd_li;

  assign rd_li  = IDX_W'(rd_slot - 1'b1);
  assign rd_dir = (rd_slot == '0) ? '0 : regs_q[rd_li];

  // Entries at or above NUM_LIGHTS are never written and stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en && wr_allow && (int'(wr_idx) < NUM_LIGHTS)) begin
      regs_q[wr_idx] <= wr_dir;
    end
  end

endmodule

// File: rtl/multi_light_intensity.sv
// Per-triangle backface cull plus clamped multi-light diffuse sum over one shared
// pipelined dot unit. Define MULTI_LIGHT_MASK_EN to add a per-light enable mask.
module multi_light_intensity
  import shader_pkg::*;
#(
  parameter int NORM_WIDTH   = 16,
  parameter int NORM_FRAC    = 14,
  parameter int NUM_LIGHTS   = 4,
  parameter int DOT_LATENCY  = 4,
  parameter int AMBIENT      = 1638,
  parameter int CAM_IS_LIGHT = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and data is held stable while valid is high.
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3*NORM_WIDTH-1:0]       tri_norm,
  input  logic [3*NORM_WIDTH-1:0]       cam_norm,
`ifdef MULTI_LIGHT_MASK_EN
  input  logic [NUM_LIGHTS-1:0]         light_mask_in,
`endif
  input  logic                          light_wr_en,
  input  logic [idx_w(NUM_LIGHTS)-1:0]  light_wr_idx,
  input  logic [3*NORM_WIDTH-1:0]       light_wr_dir,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [NORM_WIDTH-1:0]  intensity_out,
  output logic                          culled_out,
  output logic [1:0]                    dbg_state
);

  localparam int N_SLOTS = NUM_LIGHTS + 1;
  localparam int SLOT_W  = $clog2(N_SLOTS);
  localparam int VEC_W   = 3 * NORM_WIDTH;
  localparam int FULL_W  = full_w(NORM_WIDTH, NORM_FRAC);
  localparam int ACC_W   = acc_w(NORM_WIDTH, NORM_FRAC, NUM_LIGHTS);
  localparam logic signed [ACC_W-1:0] ONE_ACC = ACC_W'(one_q(NORM_FRAC));

  state_t                     state_q, state_d;
  logic [SLOT_W-1:0]          slot_q;
  logic [VEC_W-1:0]           tri_q, cam_q;
  logic [NUM_LIGHTS-1:0]      mask_q;
  logic [DOT_LATENCY-1:0]     tag_v_q;
  logic [SLOT_W-1:0]          tag_s_q [DOT_LATENCY];
  logic signed [ACC_W-1:0]    acc_q;
  logic                       cull_q, done_q;

  logic                       accept, issue, last_slot;
  logic [VEC_W-1:0]           light_rd, dot_b;
  logic signed [FULL_W-1:0]   dot_res;
  logic                       retire, retire_last;
  logic [SLOT_W-1:0]          rslot;
  logic [N_SLOTS-1:0]         lit_en;
  logic signed [ACC_W-1:0]    d_ext, neg_d, contrib, sat;
  logic signed [NORM_WIDTH-1:0] intensity_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  assign issue     = (state_q == ISSUE);
  assign last_slot = (slot_q == SLOT_W'(N_SLOTS - 1));

  light_dir_regfile #(.NORM_WIDTH(NORM_WIDTH), .NUM_LIGHTS(NUM_LIGHTS)) u_lights (
    .clk(clk_in), .rst_n(rst_n_in), .wr_allow(state_q == IDLE),
    .wr_en(light_wr_en), .wr_idx(light_wr_idx), .wr_dir(light_wr_dir),
    .rd_slot(slot_q), .rd_dir(light_rd)
  );

  assign dot_b = (slot_q == '0) ? cam_q : light_rd;

  fixed_point_fast_dot #(.NORM_WIDTH(NORM_WIDTH), .NORM_FRAC(NORM_FRAC), .LATENCY(DOT_LATENCY)) u_dot (
    .clk(clk_in), .rst_n(rst_n_in), .a(tri_q), .b(dot_b), .y(dot_res)
  );

  // Retiring slot: bit 0 of lit_en is the headlight, bit i the mask of light i-1.
  assign retire      = tag_v_q[DOT_LATENCY-1];
  assign rslot       = tag_s_q[DOT_LATENCY-1];
  assign retire_last = retire && (rslot == SLOT_W'(N_SLOTS - 1));
  assign lit_en      = {mask_q, (CAM_IS_LIGHT != 0)};
  assign d_ext       = {{(ACC_W - FULL_W){dot_res[FULL_W-1]}}, dot_res};
  assign neg_d       = -d_ext;
  assign contrib     = (lit_en[rslot] && !neg_d[ACC_W-1] && (neg_d != '0)) ? neg_d : '0;
  assign sat         = (acc_q > ONE_ACC) ? ONE_ACC : acc_q;
  assign intensity_d = cull_q ? '0 : sat[NORM_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ISSUE;
      ISSUE:   if (last_slot) state_d = DRAIN;
      DRAIN:   if (done_q)    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      tri_q         <= '0;
      cam_q         <= '0;
      tag_v_q       <= '0;
      for (int k = 0; k < DOT_LATENCY; k++) tag_s_q[k] <= '0;
      acc_q         <= '0;
      cull_q        <= 1'b0;
      done_q        <= 1'b0;
      intensity_out <= '0;
      culled_out    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= (issue && !last_slot) ? slot_q + 1'b1 : '0;
      tag_v_q <= {tag_v_q[DOT_LATENCY-2:0], issue};
      tag_s_q[0] <= slot_q;
      for (int k = 1; k < DOT_LATENCY; k++) tag_s_q[k] <= tag_s_q[k-1];
      done_q  <= retire_last;
      if (accept) begin
        tri_q  <= tri_norm;
        cam_q  <= cam_norm;
        acc_q  <= ACC_W'(AMBIENT);
        cull_q <= 1'b0;
      end else if (retire) begin
        acc_q <= acc_q + contrib;
        if (rslot == '0) cull_q <= !d_ext[ACC_W-1] && (d_ext != '0);
      end
      if (state_q == DRAIN && done_q) begin
        intensity_out <= intensity_d;
        culled_out    <= cull_q;
      end
    end
  end

`ifdef MULTI_LIGHT_MASK_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   mask_q <= '0;
    else if (accept) mask_q <= light_mask_in;
  end
`else
  assign mask_q = '1;
`endif

endmodule

// File: tb/tb_multi_light_intensity.sv
// Directed bench for multi_light_intensity (NUM_LIGHTS=2, headlight on) with a
// queue scoreboard checked by a separate output monitor.
module tb_multi_light_intensity;
  import shader_pkg::*;

  localparam int NW = 16;

  logic              clk, rst_n;
  logic              in_valid, in_ready;
  vec3_t             tri_norm, cam_norm;
  logic [1:0]        light_mask_in;
  logic              light_wr_en;
  logic [0:0]        light_wr_idx;
  vec3_t             light_wr_dir;
  logic              out_valid, out_ready;
  logic signed [NW-1:0] intensity_out;
  logic              culled_out;
  logic [1:0]        dbg_state;

  logic [16:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  multi_light_intensity #(
    .NORM_WIDTH(16), .NORM_FRAC(14), .NUM_LIGHTS(2), .DOT_LATENCY(4),
    .AMBIENT(1638), .CAM_IS_LIGHT(1)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .tri_norm(tri_norm), .cam_norm(cam_norm),
`ifdef MULTI_LIGHT_MASK_EN
    .light_mask_in(light_mask_in),
`endif
    .light_wr_en(light_wr_en), .light_wr_idx(light_wr_idx), .light_wr_dir(light_wr_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .intensity_out(intensity_out), .culled_out(culled_out),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, exp_q size %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic vec3_t v3(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic set_light(input int idx, input vec3_t dir);
    light_wr_en  = 1'b1;
    light_wr_idx = 1'(idx);
    light_wr_dir = dir;
    @(posedge clk); #1;
    light_wr_en  = 1'b0;
  endtask

  task automatic accept_tri(input vec3_t t, input vec3_t c, input logic culled,
                            input int inten, input bit push);
    int n;
    n = 0;
    tri_norm = t;
    cam_norm = c;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(n), 32'd0);
    if (push) exp_q.push_back({culled, 16'(inten)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(n), 32'd0);
    else if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic run_tri(input vec3_t t, input vec3_t c, input logic culled, input int inten);
    accept_tri(t, c, culled, inten, 1'b1);
    wait_out(8);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] exp;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL result_unexpected: got culled=%0b intensity=%0d, expected no output",
                 culled_out, intensity_out);
      end else begin
        exp = exp_q.pop_front();
        check("result", {15'd0, culled_out, intensity_out}, {15'd0, exp});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tri_norm = '0; cam_norm = '0; light_mask_in = 2'b11;
    light_wr_en = 1'b0; light_wr_idx = '0; light_wr_dir = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_intensity", 32'(intensity_out), 32'd0);
    check("rst_culled", 32'(culled_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // culling: d0 = +1.0 with zero lights
    run_tri(v3(0, 0, 16384), v3(0, 0, 16384), 1'b1, 0);
    // headlight saturation: 1638 + 16384 clamps to 16384
    run_tri(v3(0, 0, -16384), v3(0, 0, 16384), 1'b0, 16384);

    // multi-light sum with d0 == 0 (not culled, no headlight term)
    set_light(0, v3(0, 0, 16384));
    set_light(1, v3(0, 16384, 0));
    run_tri(v3(0, 0, -8192), v3(16384, 0, 0), 1'b0, 9830);
    // mixed signs: headlight 2048, L0 2048, L1 faces away -> 1638+4096
    run_tri(v3(0, 4096, -2048), v3(0, 0, 16384), 1'b0, 5734);

    // backpressure: hold result 20 cycles while a second triangle waits
    out_ready = 1'b0;
    accept_tri(v3(0, 4096, -2048), v3(0, 0, 16384), 1'b0, 5734, 1'b1);
    wait_out(8);
    tri_norm = v3(0, 0, -16384);
    cam_norm = v3(0, 0, 16384);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {13'd0, out_valid, in_ready, culled_out, intensity_out},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'd5734});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    run_tri(v3(0, 0, -16384), v3(0, 0, 16384), 1'b0, 16384);

    // write during DRAIN is dropped
    accept_tri(v3(0, 0, -8192), v3(16384, 0, 0), 1'b0, 9830, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("drain_state", 32'(dbg_state), 32'(DRAIN));
    set_light(0, v3(0, 0, 0));
    wait_out(-1);
    @(posedge clk); #1;
    run_tri(v3(0, 0, -8192), v3(16384, 0, 0), 1'b0, 9830);
    // write in the accept cycle applies to that triangle
    light_wr_en = 1'b1; light_wr_idx = 1'b0; light_wr_dir = v3(0, 0, 0);
    accept_tri(v3(0, 0, -8192), v3(16384, 0, 0), 1'b0, 1638, 1'b1);
    light_wr_en = 1'b0;
    wait_out(8);
    @(posedge clk); #1;

`ifdef MULTI_LIGHT_MASK_EN
    // L1 masked off: only L0 counts -> 1638 + 2048
    set_light(0, v3(0, 0, 16384));
    light_mask_in = 2'b01;
    run_tri(v3(0, -4096, -2048), v3(16384, 0, 0), 1'b0, 3686);
    light_mask_in = 2'b11;
`endif

    // async reset mid-ISSUE
    set_light(0, v3(0, 0, 16384));
    accept_tri(v3(0, 0, -8192), v3(16384, 0, 0), 1'b0, 0, 1'b0);
    check("issue_state", 32'(dbg_state), 32'(ISSUE));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_intensity", 32'(intensity_out), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    check("no_stale_out_valid", 32'(cnt), 32'd0);
    // reset cleared L0, so only ambient remains
    run_tri(v3(0, 0, -8192), v3(16384, 0, 0), 1'b0, 1638);
    run_tri(v3(0, 0, -16384), v3(0, 0, 16384), 1'b0, ONE);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_light_intensity.md
Name: multi_light_intensity

Overview:
Parametrised successor to the single-light intensity stage in the shader path. Per accepted triangle it computes one camera dot for backface culling, plus one dot for each of NUM_LIGHTS stored directional lights. Per-light contributions are clamped, accumulated with an ambient term and saturated to [0, 1.0]. It sits between triangle setup and the rasteriser colour stage, with valid/ready on both sides, and time-multiplexes one shared pipelined dot unit.

Parameters:
NORM_WIDTH, 16, signed width of normal components and of the intensity output
NORM_FRAC, 14, fractional bits; ONE = 1<<NORM_FRAC
NUM_LIGHTS, 4, stored light directions (1..16)
DOT_LATENCY, 4, pipeline latency of the dot unit in cycles
AMBIENT, 1638, ambient intensity in Q(NORM_FRAC) (about 0.1)
CAM_IS_LIGHT, 1, 1 = camera direction also contributes as a headlight

Ports:
clk_in  in  1  clock
rst_n_in  in  1  asynchronous active-low reset
in_valid  in  1  triangle normal valid
in_ready  out  1  block can accept a triangle
tri_norm  in  3xNORM_WIDTH  signed triangle normal (x,y,z)
cam_norm  in  3xNORM_WIDTH  signed camera view direction
light_wr_en  in  1  light register write strobe
light_wr_idx  in  clog2(NUM_LIGHTS)  light slot to write
light_wr_dir  in  3xNORM_WIDTH  signed light direction, pointing toward the surface
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
intensity_out  out  NORM_WIDTH  signed intensity in [0, ONE]
culled_out  out  1  triangle is back-facing

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, in_ready=1, out_valid=0, intensity_out=0, culled_out=0, accumulator=0. All light registers are 0, so they contribute nothing.
- Slots: N_SLOTS = NUM_LIGHTS+1. Slot 0 = tri·cam; slot i = tri·light[i-1].
- FSM IDLE: in_ready=1. On in_valid&&in_ready, capture tri_norm and cam_norm, then go to ISSUE.
- FSM ISSUE: one slot per cycle, slot index counter 0..N_SLOTS-1. After the last issue, go to DRAIN.
- FSM DRAIN: wait for the DOT_LATENCY tail. A valid-tag shift register of length DOT_LATENCY tracks in-flight slots. When the last slot retires, go to OUT.
- FSM OUT: out_valid=1; intensity_out and culled_out are stable. On out_ready, go to IDLE.
- in_ready=0 in ISSUE, DRAIN and OUT. No overlap between triangles.
- Latency: out_valid rises N_SLOTS+DOT_LATENCY+1 cycles after the accept edge. Throughput is one triangle per N_SLOTS+DOT_LATENCY+2 cycles when out_ready=1.
- Dot width: FULL = 2+2*NORM_WIDTH-NORM_FRAC, signed Q(NORM_FRAC).
- Slot 0 result d0: culled = (d0 > 0); d0 == 0 is not culled.
- Contribution of each lit slot: c = max(0, -d). Slot 0 contributes only if CAM_IS_LIGHT=1.
- Accumulator width: FULL + clog2(N_SLOTS) + 1, no internal wrap. Initialised to AMBIENT at accept.
- Final result: intensity = min(acc, ONE). If culled: intensity_out=0, culled_out=1, and the triangle is still output.
- Light writes are honoured only in IDLE, including the accept cycle, where the new value applies to this triangle. Writes in other states are dropped silently.
- light_wr_idx >= NUM_LIGHTS is ignored.
- A write and an accept in the same IDLE cycle are both performed.
- Reset mid-operation: in-flight slots are discarded, tag pipe and FSM are cleared, and no stale out_valid appears after release.

Optional Feature:
Macro MULTI_LIGHT_MASK_EN.
- Defined: adds input light_mask_in [NUM_LIGHTS], captured at accept. A light with a cleared mask bit contributes 0. Its slot is still issued, so latency is unchanged.
- Undefined: the port is absent and all lights are enabled.

Decomposition:
- shader_pkg holds:
  - typedef vec3_t (3xNORM_WIDTH signed)
  - the FSM state enum {IDLE, ISSUE, DRAIN, OUT}
  - localparam functions for FULL width and accumulator width
  - constant ONE
- Reuse the existing fixed_point_fast_dot as the dot unit; DOT_LATENCY must equal its latency.
- One natural new sub-module: light_dir_regfile. It holds NUM_LIGHTS x vec3_t, has one write port and one combinational read port indexed by the slot counter, and applies the IDLE-only write gating.

Test Plan:
- Culling, NUM_LIGHTS=2, CAM_IS_LIGHT=1, lights zero. tri=(0,0,16384), cam=(0,0,16384) -> d0=16384, culled_out=1, intensity_out=0, out_valid 8 cycles after accept.
- Headlight saturation. tri=(0,0,-16384), cam=(0,0,16384) -> culled_out=0; 1638+16384 clamps to intensity_out=16384.
- Multi-light sum, CAM_IS_LIGHT=0. L0=(0,0,16384), L1=(0,16384,0), tri=(0,0,-8192), cam=(0,0,16384) -> contributions 8192 and 0; intensity_out=9830.
- Backpressure. Hold out_ready=0 for 20 cycles -> out_valid, intensity_out and culled_out stable; in_ready=0 throughout. Second triangle is accepted only after the out_ready handshake.
- Write gating. Write L0 during DRAIN -> ignored; current result unchanged. The same write in the IDLE accept cycle is used by that triangle.
- Async reset. Assert rst_n_in mid-ISSUE -> outputs reach reset values immediately; no out_valid after release until a new triangle completes. With MULTI_LIGHT_MASK_EN, mask=0b01 on the test 3 setup -> 9830 (only L0 counted).
